// File: rtl/multicycle_control_if.sv
// Control-unit bundle: opcode/mem_ready in from memory, control strobes and status out to the datapath.
interface multicycle_control_if #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                IRWrite;
  logic                ALUSrc;
  logic                MemtoReg;
  logic                RegWrite;
  logic                MemRead;
  logic                MemWrite;
  logic                Branch;
  logic [ALUOP_W-1:0]  Aluop;
  logic [2:0]          state;
  logic                error;
  logic [1:0]          err_code;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, Aluop, state, error, err_code, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, Aluop, state, error, err_code, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory-ready wait, illegal-opcode and memory-timeout trapping, and a retire counter.
module multicycle_control #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(7'b1100011);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                retire;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      wait_q     <= '0;
      retired_q  <= '0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // wait_d defaults to zero, so the counter is cleared on every entry into FETCH/MEM
  // and only counts while a wait state is held without mem_ready.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = '0;
    error_d    = error_q;
    err_code_d = err_code_q;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = bus.opcode;
        if (is_legal(bus.opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = 2'b01;
        end
      end
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = 2'b11;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
        error_d = 1'b1;
      end
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // Strobes are forced low while rst is held so nothing is issued to memory during reset.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Branch   = 1'b0;
    bus.Aluop    = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_EXEC: begin
          if (op_q == OP_R) begin
            bus.Aluop = ALUOP_W'(2'b10);
          end else if (op_q == OP_I) begin
            bus.Aluop  = ALUOP_W'(2'b11);
            bus.ALUSrc = 1'b1;
          end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
            bus.Aluop  = ALUOP_W'(2'b00);
            bus.ALUSrc = 1'b1;
          end else if (op_q == OP_BEQ) begin
            bus.Aluop  = ALUOP_W'(2'b01);
            bus.Branch = 1'b1;
          end
        end
        S_MEM: begin
          bus.MemRead  = (op_q == OP_LW);
          bus.MemWrite = (op_q == OP_SW);
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = (op_q == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_code_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one slot per clock cycle, outputs checked mid-cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] JUNK   = 7'b1111111;

  // {PCWrite, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch}
  localparam logic [7:0] C_NONE  = 8'b00000000;
  localparam logic [7:0] C_FR    = 8'b11000100;
  localparam logic [7:0] C_FW    = 8'b00000100;
  localparam logic [7:0] C_EXIMM = 8'b00100000;
  localparam logic [7:0] C_BR    = 8'b00000001;
  localparam logic [7:0] C_MRD   = 8'b00000100;
  localparam logic [7:0] C_MWR   = 8'b00000010;
  localparam logic [7:0] C_WB    = 8'b00001000;
  localparam logic [7:0] C_WBLW  = 8'b00011000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_control_if #(.OPCODE_W(7), .ALUOP_W(2), .CNT_W(16)) bus ();
  multicycle_control_if #(.OPCODE_W(7), .ALUOP_W(2), .CNT_W(2))  bus2 ();

  multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT(16), .CNT_W(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic slot(input logic r, input logic mr, input logic [6:0] op);
    @(posedge clk);
    #1;
    rst            = r;
    bus.mem_ready  = mr;
    bus.opcode     = op;
    bus2.mem_ready = mr;
    bus2.opcode    = op;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] st, input logic [7:0] ctl,
                         input logic [1:0] aop);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ctl"}, 32'({bus.PCWrite, bus.IRWrite, bus.ALUSrc, bus.MemtoReg,
                            bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch}), 32'(ctl));
    chk({tag, ".aluop"}, 32'(bus.Aluop), 32'(aop));
  endtask

  task automatic chk_stat(input string tag, input logic err, input logic [1:0] code,
                          input logic [15:0] ret);
    chk({tag, ".error"}, 32'(bus.error), 32'(err));
    chk({tag, ".err_code"}, 32'(bus.err_code), 32'(code));
    chk({tag, ".retired"}, 32'(bus.retired), 32'(ret));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.mem_ready  = 1'b0;
    bus.opcode     = '0;
    bus2.mem_ready = 1'b0;
    bus2.opcode    = '0;

    // reset, mem_ready high must not leak through
    slot(1, 1, JUNK);
    slot(1, 1, JUNK);
    chk_ctl("rst", 3'd0, C_NONE, 2'b00);
    chk_stat("rst", 1'b0, 2'b00, 16'd0);

    // R-type, zero wait
    slot(0, 1, JUNK);   chk_ctl("r_fetch", 3'd0, C_FR, 2'b00);
    slot(0, 1, OP_R);   chk_ctl("r_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("r_exec", 3'd2, C_NONE, 2'b10);
    slot(0, 1, JUNK);   chk_ctl("r_wb", 3'd4, C_WB, 2'b00);
    chk("r_wb.retired", 32'(bus.retired), 32'd0);

    // LW with 3 wait cycles in MEM
    slot(0, 1, JUNK);   chk_ctl("lw_fetch", 3'd0, C_FR, 2'b00);
    chk("r_done.retired", 32'(bus.retired), 32'd1);
    slot(0, 1, OP_LW);  chk_ctl("lw_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 0, JUNK);   chk_ctl("lw_exec", 3'd2, C_EXIMM, 2'b00);
    for (int i = 0; i < 3; i++) begin
      slot(0, 0, JUNK); chk_ctl("lw_mem_wait", 3'd3, C_MRD, 2'b00);
    end
    slot(0, 1, JUNK);   chk_ctl("lw_mem_rdy", 3'd3, C_MRD, 2'b00);
    slot(0, 0, JUNK);   chk_ctl("lw_wb", 3'd4, C_WBLW, 2'b00);

    // SW, BEQ, I back to back
    slot(0, 1, JUNK);   chk_ctl("sw_fetch", 3'd0, C_FR, 2'b00);
    chk("lw_done.retired", 32'(bus.retired), 32'd2);
    slot(0, 1, OP_SW);  chk_ctl("sw_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("sw_exec", 3'd2, C_EXIMM, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("sw_mem", 3'd3, C_MWR, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("beq_fetch", 3'd0, C_FR, 2'b00);
    chk("sw_done.retired", 32'(bus.retired), 32'd3);
    slot(0, 1, OP_BEQ); chk_ctl("beq_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("beq_exec", 3'd2, C_BR, 2'b01);
    slot(0, 1, JUNK);   chk_ctl("i_fetch", 3'd0, C_FR, 2'b00);
    chk("beq_done.retired", 32'(bus.retired), 32'd4);
    slot(0, 1, OP_I);   chk_ctl("i_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("i_exec", 3'd2, C_EXIMM, 2'b11);
    slot(0, 1, JUNK);   chk_ctl("i_wb", 3'd4, C_WB, 2'b00);

    // fetch timeout: 16 cycles without mem_ready
    slot(0, 0, JUNK);   chk_ctl("to_fetch", 3'd0, C_FW, 2'b00);
    chk_stat("i_done", 1'b0, 2'b00, 16'd5);
    for (int i = 1; i < 16; i++) begin
      slot(0, 0, JUNK); chk_ctl("to_wait", 3'd0, C_FW, 2'b00);
    end
    slot(0, 0, JUNK);   chk_ctl("to_err", 3'd5, C_NONE, 2'b00);
    chk_stat("to_err", 1'b1, 2'b10, 16'd5);
    slot(0, 1, JUNK);   chk_ctl("to_err_hold", 3'd5, C_NONE, 2'b00);
    slot(1, 0, JUNK);
    slot(1, 0, JUNK);   chk_ctl("to_rst", 3'd0, C_NONE, 2'b00);
    chk_stat("to_rst", 1'b0, 2'b00, 16'd0);

    // mem_ready on the 16th fetch cycle wins over the timeout
    for (int i = 0; i < 15; i++) begin
      slot(0, 0, JUNK); chk_ctl("edge_wait", 3'd0, C_FW, 2'b00);
    end
    slot(0, 1, JUNK);   chk_ctl("edge_rdy", 3'd0, C_FR, 2'b00);
    slot(0, 1, OP_BEQ); chk_ctl("edge_dec", 3'd1, C_NONE, 2'b00);
    chk_stat("edge_dec", 1'b0, 2'b00, 16'd0);
    slot(0, 1, JUNK);   chk_ctl("edge_exec", 3'd2, C_BR, 2'b01);

    // illegal opcode
    slot(0, 1, JUNK);   chk_ctl("ill_fetch", 3'd0, C_FR, 2'b00);
    chk("edge_done.retired", 32'(bus.retired), 32'd1);
    slot(0, 1, JUNK);   chk_ctl("ill_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("ill_err", 3'd5, C_NONE, 2'b00);
    chk_stat("ill_err", 1'b1, 2'b01, 16'd1);
    for (int i = 0; i < 20; i++) begin
      slot(0, logic'(i % 2), OP_BEQ); chk_ctl("ill_hold", 3'd5, C_NONE, 2'b00);
    end
    chk_stat("ill_hold", 1'b1, 2'b01, 16'd1);
    slot(1, 1, JUNK);
    slot(1, 1, JUNK);   chk_ctl("ill_rst", 3'd0, C_NONE, 2'b00);
    chk_stat("ill_rst", 1'b0, 2'b00, 16'd0);

    // reset during MEM of a store drops the write
    slot(0, 1, JUNK);   chk_ctl("ab_fetch", 3'd0, C_FR, 2'b00);
    slot(0, 1, OP_SW);  chk_ctl("ab_dec", 3'd1, C_NONE, 2'b00);
    slot(0, 1, JUNK);   chk_ctl("ab_exec", 3'd2, C_EXIMM, 2'b00);
    slot(0, 0, JUNK);   chk_ctl("ab_mem", 3'd3, C_MWR, 2'b00);
    slot(1, 0, JUNK);   chk_ctl("ab_rst", 3'd3, C_NONE, 2'b00);
    slot(0, 0, JUNK);   chk_ctl("ab_after", 3'd0, C_FW, 2'b00);
    chk_stat("ab_after", 1'b0, 2'b00, 16'd0);

    // five BEQs: 16-bit counter reads 5, 2-bit counter wraps to 1
    for (int i = 0; i < 5; i++) begin
      slot(0, 1, JUNK);   chk_ctl("wrap_fetch", 3'd0, C_FR, 2'b00);
      slot(0, 1, OP_BEQ); chk_ctl("wrap_dec", 3'd1, C_NONE, 2'b00);
      slot(0, 1, JUNK);   chk_ctl("wrap_exec", 3'd2, C_BR, 2'b01);
    end
    slot(0, 0, JUNK);
    chk("wrap.retired16", 32'(bus.retired), 32'd5);
    chk("wrap.retired2", 32'(bus2.retired), 32'd1);
    chk("wrap.state2", 32'(bus2.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
